fp_mult_pipe: RTL

- Parametrised, pipelined IEEE-754-style floating-point multiplier for the processing element; it supersedes the combinational half-precision multiplier.
- Generalised exponent/mantissa widths: FP16 by default, FP32 by parameter.
- Three-stage valid/ready pipeline with backpressure, selectable rounding, special-value handling, status flags and a pass-through tag.
- Feeds the PE accumulator.

---
 rtl/fp_mult_pipe_if.sv | 32 +++
 rtl/fp_mult_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe_if.sv
// rtl/fp_mult_pipe_if.sv - operand/result handshake bundle for the pipelined FP multiplier
interface fp_mult_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             rnd_mode;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] tag_out;
    logic             flag_ovf;
    logic             flag_unf;
    logic             flag_inv;

    modport slave (
        input  in_valid, a, b, rnd_mode, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out, flag_ovf, flag_unf, flag_inv
    );

    modport master (
        output in_valid, a, b, rnd_mode, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out, flag_ovf, flag_unf, flag_inv
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - three-stage valid/ready floating-point multiplier with flags and tag
module fp_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    fp_mult_pipe_if.slave   bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW2  = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic signed [EW2-1:0] EXP_OVF = EW2'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    logic s1_v, s2_v, s3_v;
    logic load1, load2, load3;

    // Each stage may load when it is empty or its occupant moves on this cycle.
    assign load3        = !s3_v || bus.out_ready;
    assign load2        = !s2_v || load3;
    assign load1        = !s1_v || load2;
    assign bus.in_ready = load1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            if (load1) s1_v <= bus.in_valid;
            if (load2) s2_v <= s1_v;
            if (load3) s3_v <= s2_v;
        end
    end

    // S1: unpack and classify
    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    cls_t                  cls_c;
    logic                  inv_c;
    logic signed [EW2-1:0] exp_c;

    always_comb begin
        {sa, ea, fa} = bus.a;
        {sb, eb, fb} = bus.b;
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        cls_c  = CLS_NUM;
        inv_c  = 1'b0;
        if (a_nan || b_nan) begin
            cls_c = CLS_NAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            cls_c = CLS_NAN;
            inv_c = 1'b1;
        end else if (a_inf || b_inf) begin
            cls_c = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_c = CLS_ZERO;
        end
        exp_c = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
    end

    logic                  s1_sign, s1_inv, s1_rnd;
    cls_t                  s1_cls;
    logic [MAN_W:0]        s1_ma, s1_mb;
    logic signed [EW2-1:0] s1_exp;
    logic [TAG_W-1:0]      s1_tag;

    always_ff @(posedge clk) begin
        if (load1) begin
            s1_sign <= sa ^ sb;
            s1_cls  <= cls_c;
            s1_inv  <= inv_c;
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
            s1_exp  <= exp_c;
            s1_rnd  <= bus.rnd_mode;
            s1_tag  <= bus.tag_in;
        end
    end

    // S2: mantissa multiply
    logic                  s2_sign, s2_inv, s2_rnd;
    cls_t                  s2_cls;
    logic [PW-1:0]         s2_prod;
    logic signed [EW2-1:0] s2_exp;
    logic [TAG_W-1:0]      s2_tag;

    always_ff @(posedge clk) begin
        if (load2) begin
            s2_sign <= s1_sign;
            s2_cls  <= s1_cls;
            s2_inv  <= s1_inv;
            s2_prod <= PW'(s1_ma) * PW'(s1_mb);
            s2_exp  <= s1_exp;
            s2_rnd  <= s1_rnd;
            s2_tag  <= s1_tag;
        end
    end

    // S3: normalise, round, detect range errors and pack
    logic                  msb, guard, sticky, inc;
    logic [MAN_W-1:0]      frac;
    logic [MAN_W:0]        frac_r;
    logic signed [EW2-1:0] exp_n, exp_r;
    logic [W-1:0]          res_c;
    logic                  ovf_c, unf_c, flg_inv_c;

    always_comb begin
        msb    = s2_prod[PW-1];
        frac   = msb ? s2_prod[PW-2 -: MAN_W] : s2_prod[PW-3 -: MAN_W];
        guard  = msb ? s2_prod[PW-2-MAN_W] : s2_prod[PW-3-MAN_W];
        sticky = msb ? |s2_prod[PW-3-MAN_W:0] : |s2_prod[PW-4-MAN_W:0];
        exp_n  = s2_exp + EW2'(msb);
        inc    = !s2_rnd && guard && (sticky || frac[0]);
        // A carry out leaves the fraction bits at zero, i.e. mantissa 1.0 at the next exponent.
        frac_r = {1'b0, frac} + (MAN_W+1)'(inc);
        exp_r  = exp_n + EW2'(frac_r[MAN_W]);
        res_c     = '0;
        ovf_c     = 1'b0;
        unf_c     = 1'b0;
        flg_inv_c = 1'b0;
        case (s2_cls)
            CLS_NAN: begin
                res_c     = QNAN;
                flg_inv_c = s2_inv;
            end
            CLS_INF:  res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            CLS_ZERO: res_c = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (exp_r >= EXP_OVF) begin
                    ovf_c = 1'b1;
                    res_c = s2_rnd ? {s2_sign, EXP_MAXF, {MAN_W{1'b1}}}
                                   : {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
                end else if (exp_r <= 0) begin
                    unf_c = 1'b1;
                    res_c = {s2_sign, {(W-1){1'b0}}};
                end else begin
                    res_c = {s2_sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                end
            end
        endcase
    end

    logic [W-1:0]     result_q;
    logic [TAG_W-1:0] tag_q;
    logic             ovf_q, unf_q, inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            tag_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else if (load3) begin
            result_q <= s2_v ? res_c : '0;
            tag_q    <= s2_v ? s2_tag : '0;
            ovf_q    <= s2_v && ovf_c;
            unf_q    <= s2_v && unf_c;
            inv_q    <= s2_v && flg_inv_c;
        end
    end

    assign bus.out_valid = s3_v;
    assign bus.result    = result_q;
    assign bus.tag_out   = tag_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_unf  = unf_q;
    assign bus.flag_inv  = inv_q;
endmodule
